// File: rtl/spart_tx_fifo.sv
// SPART transmit path: a small byte FIFO feeding an 8N1 serialiser on txd.
// Bit time comes from divisor_buffer, which is latched at every frame start.
module spart_tx_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tx_begin,
  input  logic [DATA_W-1:0]        transmit_buffer,
  input  logic [DIV_W-1:0]         divisor_buffer,
  output logic                     tbr,
  output logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   tx_count,
  output logic                     tx_ovf,
  output logic                     txd,
  output logic [1:0]               tx_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DATA_W);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [DATA_W-1:0]   shift_q, shift_n;
  logic [DIV_W-1:0]    div_q, div_n, div_clamped;
  logic [DIV_W-1:0]    baud_q, baud_n;
  logic [IW-1:0]       idx_q, idx_n;
  logic                txd_n;
  logic                push, pop, launch;

  // Handshake: tx_begin is a one-cycle strobe; it is accepted when tbr=1 at
  // the same rising edge, otherwise the byte is dropped and tx_ovf sticks.
  assign tbr         = (tx_count != FULL);
  assign push        = tx_begin & tbr;
  assign tx_busy     = (state != IDLE) | (tx_count != '0);
  assign tx_state    = state;
  assign div_clamped = (divisor_buffer < DIV_W'(2)) ? DIV_W'(2) : divisor_buffer;

  always_comb begin
    state_n = state;
    shift_n = shift_q;
    div_n   = div_q;
    baud_n  = baud_q;
    idx_n   = idx_q;
    txd_n   = txd;
    pop     = 1'b0;
    launch  = 1'b0;
    case (state)
      IDLE: begin
        txd_n = 1'b1;
        if (tx_count != '0) launch = 1'b1;
      end
      START: begin
        if (baud_q == '0) begin
          state_n = DATA;
          idx_n   = '0;
          baud_n  = div_q - DIV_W'(1);
          txd_n   = shift_q[0];
        end else begin
          baud_n = baud_q - DIV_W'(1);
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_n = div_q - DIV_W'(1);
          if (idx_q == LAST_BIT) begin
            state_n = STOP;
            txd_n   = 1'b1;
          end else begin
            shift_n = shift_q >> 1;
            idx_n   = idx_q + IW'(1);
            txd_n   = shift_q[1];
          end
        end else begin
          baud_n = baud_q - DIV_W'(1);
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          // Chain straight into the next start bit when more data is queued.
          if (tx_count != '0) begin
            launch = 1'b1;
          end else begin
            state_n = IDLE;
            txd_n   = 1'b1;
          end
        end else begin
          baud_n = baud_q - DIV_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    if (launch) begin
      pop     = 1'b1;
      shift_n = mem[rd_ptr];
      div_n   = div_clamped;
      baud_n  = div_clamped - DIV_W'(1);
      state_n = START;
      txd_n   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= transmit_buffer;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_count <= '0;
      tx_ovf   <= 1'b0;
      txd      <= 1'b1;
      shift_q  <= '0;
      div_q    <= '0;
      baud_q   <= '0;
      idx_q    <= '0;
    end else begin
      state   <= state_n;
      txd     <= txd_n;
      shift_q <= shift_n;
      div_q   <= div_n;
      baud_q  <= baud_n;
      idx_q   <= idx_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   tx_count <= tx_count + CW'(1);
        2'b01:   tx_count <= tx_count - CW'(1);
        default: tx_count <= tx_count;
      endcase
      if (tx_begin && !push) tx_ovf <= 1'b1;
    end
  end

endmodule
